// File: rtl/anton_neopixel_stream_pkg.sv
// Shared definitions for the NeoPixel streaming engine:
// state encoding, NRZ timing defaults and byte-walk helpers.
`ifndef ANTON_NEOPIXEL_MACROS
`define ANTON_NEOPIXEL_MACROS
`define CLOG2(x) $clog2(x)
`define BUFFER_END_DEFAULT 767
`define SANITIZE_BUFFER_END(x) (((x) < 2) ? 2 : (x))
`endif

package anton_neopixel_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_BIT,
        ST_LATCH
    } streamState_t;

    localparam int BIT_CYCLES_DEFAULT   = 25;
    localparam int T0H_CYCLES_DEFAULT   = 8;
    localparam int T1H_CYCLES_DEFAULT   = 16;
    localparam int RESET_CYCLES_DEFAULT = 1000;

    // Next byte to send; 32-bit pixels skip their 4th byte.
    function automatic logic [15:0] nextByteIdx(
        input logic [15:0] idx,
        input logic        mode32
    );
        if (mode32 && (idx[1:0] == 2'd2))
            return idx + 16'd2;
        return idx + 16'd1;
    endfunction

    // Index of the final byte of the frame, never a skipped byte.
    function automatic logic [15:0] lastByteIdx(
        input logic [12:0] maxPixel,
        input logic        limit,
        input logic        mode32,
        input logic [15:0] bufEnd
    );
        logic [15:0] m;
        logic [15:0] last;
        m = {3'b000, maxPixel};
        if (limit)
            last = mode32 ? (m << 2) + 16'd2
                          : (m << 1) + m + 16'd2;
        else
            last = bufEnd;
        if (last > bufEnd)
            last = bufEnd;
        if (mode32 && (last[1:0] == 2'd3))
            last = last - 16'd1;
        return last;
    endfunction

endpackage

// File: rtl/anton_neopixel_stream_bit_encoder.sv
// Byte serialiser: shifts a byte out MSB-first as WS2812 NRZ
// pulses and flags the last cycle of the 8th bit.
module anton_neopixel_bit_encoder
    import anton_neopixel_stream_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEFAULT,
    parameter int T0H_CYCLES = T0H_CYCLES_DEFAULT,
    parameter int T1H_CYCLES = T1H_CYCLES_DEFAULT
) (
    input  logic       busClk,
    input  logic       syncReset,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] loadByte,
    output logic       done,
    output logic       neoData
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] bitCnt;
    logic [2:0]    bitNum;
    logic [7:0]    shifter;
    logic          active;
    logic          bitWrap;

    function automatic logic highFor(
        input logic [CW-1:0] cnt,
        input logic          msb
    );
        return int'(cnt) < (msb ? T1H_CYCLES : T0H_CYCLES);
    endfunction

    assign bitWrap = active && (bitCnt == LAST_CNT);
    assign done    = bitWrap && (bitNum == 3'd7);

    // Bit timing, shifting and registered pulse output.
    always_ff @(posedge busClk) begin
        if (syncReset || clear) begin
            bitCnt  <= '0;
            bitNum  <= '0;
            shifter <= '0;
            active  <= 1'b0;
            neoData <= 1'b0;
        end else if (load) begin
            shifter <= loadByte;
            bitCnt  <= '0;
            bitNum  <= '0;
            active  <= 1'b1;
            neoData <= highFor('0, loadByte[7]);
        end else if (active) begin
            if (bitWrap) begin
                bitCnt <= '0;
                if (bitNum == 3'd7) begin
                    bitNum  <= '0;
                    active  <= 1'b0;
                    neoData <= 1'b0;
                end else begin
                    bitNum  <= bitNum + 3'd1;
                    shifter <= shifter << 1;
                    neoData <= highFor('0, shifter[6]);
                end
            end else begin
                bitCnt  <= bitCnt + 1'b1;
                neoData <= highFor(bitCnt + 1'b1, shifter[7]);
            end
        end
    end

endmodule

// File: rtl/anton_neopixel_stream.sv
// Frame-buffer walker: sequences bytes into the NRZ encoder,
// then holds the latch period and signals frame completion.
module anton_neopixel_stream
    import anton_neopixel_stream_pkg::*;
#(
    parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int BIT_CYCLES   = BIT_CYCLES_DEFAULT,
    parameter int T0H_CYCLES   = T0H_CYCLES_DEFAULT,
    parameter int T1H_CYCLES   = T1H_CYCLES_DEFAULT,
    parameter int RESET_CYCLES = RESET_CYCLES_DEFAULT,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   busClk,
    input  logic                   syncReset,
    input  logic [12:0]            regMax,
    input  logic                   regCtrlInit,
    input  logic                   regCtrlLimit,
    input  logic                   regCtrlRun,
    input  logic                   regCtrl32bit,
    output logic [BUFFER_BITS-1:0] pixelIndexComb,
    input  logic [7:0]             pixelByte,
    output logic                   streamSyncOf,
    output logic                   state,
    output logic                   neoData
);

    localparam int END_SAFE = `SANITIZE_BUFFER_END(BUFFER_END);
    localparam int LW =
        (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);

    streamState_t           stateQ;
    logic [BUFFER_BITS-1:0] byteIdx;
    logic [BUFFER_BITS-1:0] stepIdx;
    logic [15:0]            lastQ;
    logic                   mode32Q;
    logic                   lastSent;
    logic                   atLast;
    logic [LW-1:0]          latchCnt;
    logic                   encLoad;
    logic                   encDone;

    assign pixelIndexComb = byteIdx;
    assign state          = (stateQ != ST_IDLE);
    assign atLast         = (16'(byteIdx) >= lastQ);
    assign stepIdx        =
        BUFFER_BITS'(nextByteIdx(16'(byteIdx), mode32Q));

    // Hand the encoder a fresh byte after prefetch and at every
    // byte boundary that is not the end of the frame.
    assign encLoad = !regCtrlInit &&
        ((stateQ == ST_PREFETCH) ||
         ((stateQ == ST_BIT) && encDone && !lastSent));

    anton_neopixel_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_enc (
        .busClk    (busClk),
        .syncReset (syncReset),
        .clear     (regCtrlInit),
        .load      (encLoad),
        .loadByte  (pixelByte),
        .done      (encDone),
        .neoData   (neoData)
    );

    // Frame sequencer: start, byte walk, latch and completion pulse.
    always_ff @(posedge busClk) begin
        if (syncReset || regCtrlInit) begin
            stateQ       <= ST_IDLE;
            byteIdx      <= '0;
            lastQ        <= '0;
            mode32Q      <= 1'b0;
            lastSent     <= 1'b0;
            latchCnt     <= '0;
            streamSyncOf <= 1'b0;
        end else begin
            streamSyncOf <= 1'b0;
            unique case (stateQ)
                ST_IDLE: begin
                    byteIdx  <= '0;
                    lastSent <= 1'b0;
                    if (regCtrlRun) begin
                        stateQ  <= ST_PREFETCH;
                        mode32Q <= regCtrl32bit;
                        lastQ   <= lastByteIdx(regMax,
                            regCtrlLimit, regCtrl32bit,
                            16'(END_SAFE));
                    end
                end
                ST_PREFETCH: begin
                    stateQ   <= ST_BIT;
                    lastSent <= atLast;
                    if (!atLast)
                        byteIdx <= stepIdx;
                end
                ST_BIT: begin
                    if (encDone) begin
                        if (lastSent) begin
                            stateQ       <= ST_LATCH;
                            latchCnt     <= '0;
                            streamSyncOf <= (LATCH_LAST == '0);
                        end else begin
                            lastSent <= atLast;
                            if (!atLast)
                                byteIdx <= stepIdx;
                        end
                    end
                end
                ST_LATCH: begin
                    if (latchCnt == LATCH_LAST) begin
                        stateQ   <= ST_IDLE;
                        latchCnt <= '0;
                        byteIdx  <= '0;
                    end else begin
                        latchCnt     <= latchCnt + 1'b1;
                        streamSyncOf <=
                            ((latchCnt + 1'b1) == LATCH_LAST);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/anton_neopixel_stream.md
# anton_neopixel_stream

Streaming engine that sits directly downstream of the NeoPixel register/frame-buffer block. It walks the frame buffer byte by byte and drives the read address. It serialises each returned byte MSB-first into WS2812 NRZ pulses on a single data pin. It inserts the latch/reset low period after each frame and reports frame completion back to the register block.

## Interface
Parameters:
- BUFFER_END, `BUFFER_END_DEFAULT: last valid frame-buffer byte index (shared macro).
- BUFFER_BITS, `CLOG2(BUFFER_END+1): localparam, address width.
- BIT_CYCLES, 25: clocks per NRZ bit (1.25 us at 20 MHz).
- T0H_CYCLES, 8: high time for a 0 bit.
- T1H_CYCLES, 16: high time for a 1 bit.
- RESET_CYCLES, 1000: low latch period after a frame (50 us at 20 MHz).

Ports:
- busClk  in  1  sole clock.
- syncReset  in  1  synchronous, active-high reset.
- regMax  in  13  last pixel index when limit mode is on.
- regCtrlInit  in  1  abort and hold idle.
- regCtrlLimit  in  1  1: stop at pixel regMax; 0: stop at buffer end.
- regCtrlRun  in  1  start request, sampled in IDLE only.
- regCtrl32bit  in  1  1: 4 bytes per pixel, 4th skipped; 0: 3 packed bytes.
- pixelIndexComb  out  BUFFER_BITS  combinational frame-buffer read address.
- pixelByte  in  8  RAM data; valid one clock after the address.
- streamSyncOf  out  1  one-cycle pulse at end of frame latch.
- state  out  1  1 whenever not IDLE.
- neoData  out  1  serial data to LED chain, registered.

## Operation
- States: IDLE, PREFETCH, BIT, LATCH.
- IDLE -> PREFETCH when regCtrlRun=1 and regCtrlInit=0. byteIdx=0 in IDLE.
- PREFETCH lasts 1 cycle. The shifter loads pixelByte on the following edge, then the block enters BIT. byteIdx advances to the next valid byte at the same edge.
- pixelIndexComb = byteIdx at all times. This gives the registered-address RAM at least 8×BIT_CYCLES to settle before the next load.
- BIT:
  - bitCnt counts 0..BIT_CYCLES-1.
  - neoData = 1 while bitCnt < (shifter[7] ? T1H_CYCLES : T0H_CYCLES), else 0.
  - At bitCnt wrap the shifter shifts left.
  - After the 8th bit the block either loads the next byte from pixelByte with no gap (back-to-back bits) or goes to LATCH if the byte just sent was the last.
- Byte stepping:
  - 24-bit mode: +1.
  - 32-bit mode: when byteIdx[1:0]==2, jump to the next multiple of 4 (byte 3 of each pixel is never sent).
- Last byte:
  - Limit=1: pixel regMax, byte 2, i.e. 3·regMax+2 (24-bit) or 4·regMax+2 (32-bit). Computed at 16-bit width, then clipped to BUFFER_END.
  - Limit=0: BUFFER_END. In 32-bit mode, the last valid byte ≤ BUFFER_END.
- LATCH: neoData=0 for RESET_CYCLES. On the final cycle streamSyncOf=1 and the next state is IDLE.
  - The register block decides re-run (loop). A run still high in IDLE restarts the engine next cycle.
- regCtrlRun deasserting mid-frame has no effect; the frame completes.
- regCtrlInit=1 in any state: IDLE, neoData=0 and counters cleared on the next edge. No streamSyncOf is emitted.
- Mode and limit inputs are sampled on the IDLE->PREFETCH transition and held for the frame.

## Timing
- Reset values: neoData=0, streamSyncOf=0, state=0, pixelIndexComb=0, all counters 0.
- Start latency: run seen in IDLE at edge N → PREFETCH at N+1 → first neoData high at N+2.
- Frame length in cycles: 1 + 8·BIT_CYCLES·bytesSent + RESET_CYCLES, then 1 IDLE cycle minimum.
- streamSyncOf width: exactly 1 cycle. It is never asserted outside LATCH.
- syncReset has priority over regCtrlInit, and regCtrlInit over everything else.

## Structure
- Shared package/header holds state encodings, the NRZ default cycle constants, and byte-stepping helpers alongside `CLOG2` and `SANITIZE_BUFFER_END`.
- One natural sub-module, anton_neopixel_bit_encoder, owns bitCnt, the shifter and NRZ pulse generation, with load/done handshake. The parent owns the FSM and addressing.

## Test plan
- 24-bit mode, limit=1, regMax=0, bytes 0xA5,0x00,0xFF → 24 pulses with high times 16,8,16,8,8,16,8,16, then 8×8, then 8×16 cycles. Then 1000 low cycles and one streamSyncOf pulse.
- 32-bit mode, limit=1, regMax=1 → pixelIndexComb sequence 0,1,2,4,5,6; byte 3 never sent; 48 bits total.
- limit=0, BUFFER_END=11, 32-bit → bytes 0-2, 4-6, 8-10 sent (72 bits); index 11 skipped.
- regCtrlInit pulsed mid-bit of byte 1 → next cycle state=0, neoData=0; no streamSyncOf; a later run restarts from byte 0.
- Run held high (loop) → second PREFETCH exactly 2 cycles after streamSyncOf; run dropped mid-frame → frame still completes.
- syncReset asserted during LATCH → all outputs at reset values on the next edge.
